// File: rtl/l2_instr_mem_responder_pkg.sv
// Shared definitions for the instruction-side L2 stub responder:
// bus/memory width defaults, FSM state encoding and latency bounds.
package l2_instr_mem_responder_pkg;

   localparam int ADDR_W_DEF  = 32;
   localparam int MEM_AW_DEF  = 10;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;

   // Wide enough to hold LATENCY_MAX-1.
   localparam int LAT_CNT_W   = 4;

   localparam int RESP_CNT_W  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } resp_state_e;

   function automatic bit latency_ok(input int lat);
      return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
   endfunction

endpackage

// File: rtl/l2_instr_mem_array.sv
// Word array behind the L2 instruction responder. The content is fixed
// at Mem[k] = k ^ INIT_XOR and there is no write port, so it builds as a
// constant table with a combinational read port.
module l2_instr_mem_array
   import l2_instr_mem_responder_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                MEM_AW   = MEM_AW_DEF,
   parameter logic [ADDR_W-1:0] INIT_XOR = '0
)
(
   input  logic [MEM_AW-1:0] i_rd_idx,
   output logic [ADDR_W-1:0] o_rd_data
);

   localparam int DEPTH = 1 << MEM_AW;

   logic [ADDR_W-1:0] w_mem [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_word
      assign w_mem[k] = ADDR_W'(k) ^ INIT_XOR;
   end

   assign o_rd_data = w_mem[i_rd_idx];

endmodule

// File: rtl/l2_instr_mem_responder.sv
// Stub L2 instruction memory sitting on the instruction common bus.
// It captures the granted cache's address, waits LATENCY cycles, then
// drives the word on Data_Bus_Com with Data_in_Bus=1.
//
// Build option: define L2_RESP_HOLD_EN to hold the response on the bus
// until the grant falls (DONE is then unused). Without it the response
// is a single-cycle pulse followed by DONE until the grant drops.
//
// state | meaning
// IDLE  | bus released, waiting for a grant with a clean address
// WAIT  | address latched, counting down the access latency
// RESP  | driving data and Data_in_Bus=1
// DONE  | response given, waiting for the grant to drop
module l2_instr_mem_responder
   import l2_instr_mem_responder_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                MEM_AW   = MEM_AW_DEF,
   parameter int                LATENCY  = 3,
   parameter logic [ADDR_W-1:0] INIT_XOR = '0
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Com_Bus_Gnt,
   inout  wire  [ADDR_W-1:0]     Address_Com,
   inout  wire  [ADDR_W-1:0]     Data_Bus_Com,
   inout  wire                   Data_in_Bus,
   output logic                  Resp_busy,
   output logic [RESP_CNT_W-1:0] Resp_count
);

   if (!latency_ok(LATENCY)) begin : g_bad_latency
      $error("l2_instr_mem_responder: LATENCY must be within 1..15");
   end

   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

   resp_state_e             r_state;
   logic [LAT_CNT_W-1:0]    r_lat_cnt;
   logic [MEM_AW-1:0]       r_word_idx;
   logic [ADDR_W-1:0]       r_data;
   logic                    r_drive;
   logic                    r_busy;
   logic [RESP_CNT_W-1:0]   r_resp_count;

   logic                    w_addr_ok;
   logic [ADDR_W-1:0]       w_rd_data;

   // A floating or contended address bus must never start a transaction.
   assign w_addr_ok = !$isunknown(Address_Com);

   l2_instr_mem_array #(
      .ADDR_W   (ADDR_W),
      .MEM_AW   (MEM_AW),
      .INIT_XOR (INIT_XOR)
   ) u_mem (
      .i_rd_idx  (r_word_idx),
      .o_rd_data (w_rd_data)
   );

   // Bus FSM: capture, latency countdown, response and grant handshake.
   // Only the word index is latched; byte offset and bits above the
   // array depth are don't-care, so addresses wrap modulo the depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_lat_cnt    <= '0;
         r_word_idx   <= '0;
         r_data       <= '0;
         r_drive      <= 1'b0;
         r_busy       <= 1'b0;
         r_resp_count <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (Com_Bus_Gnt && w_addr_ok) begin
                  r_state    <= ST_WAIT;
                  r_word_idx <= Address_Com[MEM_AW+1:2];
                  r_lat_cnt  <= LAT_LOAD;
                  r_busy     <= 1'b1;
               end
            end

            ST_WAIT: begin
               if (!Com_Bus_Gnt) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (r_lat_cnt == '0) begin
                  r_state      <= ST_RESP;
                  r_data       <= w_rd_data;
                  r_drive      <= 1'b1;
                  r_resp_count <= r_resp_count + 1'b1;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 1'b1;
               end
            end

            ST_RESP: begin
`ifdef L2_RESP_HOLD_EN
               if (!Com_Bus_Gnt) begin
                  r_state <= ST_IDLE;
                  r_drive <= 1'b0;
                  r_busy  <= 1'b0;
               end
`else
               r_drive <= 1'b0;
               if (Com_Bus_Gnt) begin
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
`endif
            end

            ST_DONE: begin
               // Holding here while the grant stays up prevents a second
               // response to the same transaction.
               if (!Com_Bus_Gnt) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_drive <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Tri-state drivers follow the registered drive flag, so reset
   // releases the bus without waiting for a clock edge.
   assign Data_Bus_Com = r_drive ? r_data : {ADDR_W{1'bz}};
   assign Data_in_Bus  = r_drive ? 1'b1   : 1'bz;

   assign Resp_busy    = r_busy;
   assign Resp_count   = r_resp_count;

endmodule

// File: tb/tb_l2_instr_mem_responder.sv
// Bench for l2_instr_mem_responder. Released bus lines are pulled
// (data to all-ones, strobe to zero) so a released bus reads back as a
// known value. Directed reads push their expected response into a
// scoreboard; a negedge monitor pops and checks each response it sees.
module tb_l2_instr_mem_responder;

   localparam int          P_LAT = 3;
   localparam logic [31:0] P_XOR = 32'h0000_0000;
`ifdef L2_RESP_HOLD_EN
   localparam bit          HOLD  = 1'b1;
`else
   localparam bit          HOLD  = 1'b0;
`endif

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        gnt      = 1'b0;
   logic [31:0] addr_drv = 32'h0;

   wire  [31:0] Address_Com;
   tri1  [31:0] Data_Bus_Com;
   tri0         Data_in_Bus;
   logic        Resp_busy;
   logic [15:0] Resp_count;

   assign Address_Com = addr_drv;

   l2_instr_mem_responder #(
      .ADDR_W   (32),
      .MEM_AW   (10),
      .LATENCY  (P_LAT),
      .INIT_XOR (P_XOR)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Com_Bus_Gnt  (gnt),
      .Address_Com  (Address_Com),
      .Data_Bus_Com (Data_Bus_Com),
      .Data_in_Bus  (Data_in_Bus),
      .Resp_busy    (Resp_busy),
      .Resp_count   (Resp_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          checks    = 0;
   int          failures  = 0;
   int          issued    = 0;
   int          seen      = 0;
   logic [15:0] exp_count = 16'h0;

   typedef struct {
      logic [31:0] data;
      logic [15:0] cnt;
      int          cyc;
      int          len;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   bit   prev_din = 1'b0;
   int   run      = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every rising Data_in_Bus is one response, matched in order.
   always @(negedge clk) begin
      if (Data_in_Bus === 1'b1) begin
         if (!prev_din) begin
            seen++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_resp: got data %h count %h, expected no response", Data_Bus_Com, Resp_count);
               cur.data = 32'h0;
               cur.cnt  = 16'h0;
               cur.cyc  = 0;
               cur.len  = 1;
            end else begin
               cur = sb.pop_front();
               chk32("resp_data",  Data_Bus_Com,        cur.data);
               chk32("resp_count", {16'h0, Resp_count}, {16'h0, cur.cnt});
               chk32("resp_cycle", cyc,                 cur.cyc);
            end
            run = 1;
         end else begin
            run++;
         end
      end else if (prev_din) begin
         chk32("resp_len", run, cur.len);
      end
      prev_din = (Data_in_Bus === 1'b1);
   end

   // One granted read; a_later replaces the address after capture and
   // the grant is dropped hold_n cycles after the response cycle.
   task automatic do_read(input logic [31:0] a, input logic [31:0] a_later,
                          input int hold_n, input logic [31:0] exp_idx);
      exp_t e;
      @(negedge clk);
      gnt      = 1'b1;
      addr_drv = a;
      exp_count++;
      e.data = exp_idx ^ P_XOR;
      e.cnt  = exp_count;
      e.cyc  = cyc + 1 + P_LAT;
      e.len  = HOLD ? hold_n + 1 : 1;
      sb.push_back(e);
      issued++;
      @(negedge clk);
      addr_drv = a_later;
      chk32("busy_in_wait", {31'h0, Resp_busy}, 32'd1);
      repeat (P_LAT) @(negedge clk);
      repeat (hold_n) @(negedge clk);
      gnt = 1'b0;
      @(negedge clk);
      chk32("busy_after_resp",  {31'h0, Resp_busy},  32'd0);
      chk32("count_after_resp", {16'h0, Resp_count}, {16'h0, exp_count});
   endtask

   // Grant falls right after capture: nothing may be driven or counted.
   task automatic do_abort(input logic [31:0] a);
      @(negedge clk);
      gnt      = 1'b1;
      addr_drv = a;
      @(negedge clk);
      chk32("abort_busy_wait", {31'h0, Resp_busy}, 32'd1);
      gnt = 1'b0;
      @(negedge clk);
      chk32("abort_busy_idle", {31'h0, Resp_busy}, 32'd0);
      repeat (P_LAT + 2) @(negedge clk);
      chk32("abort_count", {16'h0, Resp_count}, {16'h0, exp_count});
   endtask

   // Assert reset in the middle of the response cycle.
   task automatic do_reset_mid_resp(input logic [31:0] a);
      @(negedge clk);
      gnt      = 1'b1;
      addr_drv = a;
      repeat (P_LAT) @(negedge clk);
      @(posedge clk);
      #1;
      chk32("mid_resp_din_driven", {31'h0, Data_in_Bus}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk32("async_rst_din",   {31'h0, Data_in_Bus}, 32'd0);
      chk32("async_rst_data",  Data_Bus_Com,         32'hFFFF_FFFF);
      chk32("async_rst_busy",  {31'h0, Resp_busy},   32'd0);
      chk32("async_rst_count", {16'h0, Resp_count},  32'd0);
      exp_count = 16'h0;
      gnt = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected test completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      gnt      = 1'b1;
      addr_drv = 32'h0000_0010;
      repeat (5) begin
         @(negedge clk);
         chk32("rst_din", {31'h0, Data_in_Bus}, 32'd0);
      end
      chk32("rst_data",  Data_Bus_Com,        32'hFFFF_FFFF);
      chk32("rst_busy",  {31'h0, Resp_busy},  32'd0);
      chk32("rst_count", {16'h0, Resp_count}, 32'd0);
      gnt   = 1'b0;
      rst_n = 1'b1;

      do_read(32'h0000_0010, 32'h0000_0010, 3, 32'h4);
      do_read(32'h0000_1008, 32'h0000_1008, 3, 32'h2);
      do_abort(32'h0000_0050);
      do_read(32'h0000_0014, 32'h0000_0014, 3, 32'h5);
      do_read(32'h0000_0020, 32'h0000_0040, 3, 32'h8);
      do_read(32'h0000_0013, 32'h0000_0013, 0, 32'h4);
      do_read(32'h0000_3FFC, 32'h0000_3FFC, 2, 32'h3FF);
      do_reset_mid_resp(32'h0000_0030);
      do_read(32'h0000_0000, 32'h0000_0000, 3, 32'h0);

      repeat (5) @(negedge clk);
      chk32("sb_empty",      sb.size(), 32'd0);
      chk32("resp_total",    seen,      issued);
      chk32("final_count",   {16'h0, Resp_count}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
